instr_decode_stage: RTL and testbench
=====================================

INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

Interface
REQ-001 Parameters SHALL be: ARQ, default 16, instruction width; REG_BITS, default 3, register-index width; CNT_W, default 8, stall-counter width.
REQ-002 Derived widths SHALL be: ADDR_BITS = ARQ-3 (13 at default); IMM_BITS = ARQ-3-REG_BITS (10 at default).
REQ-003 Ports SHALL be, as name, direction, width, meaning:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage accepts instruction.
- instr  in  ARQ  instruction word.
- flush  in  1  discard stage contents (taken branch).
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts bundle.
- opcode  out  3  instr[ARQ-1:ARQ-3].
- srcdest, src1, src2  out  REG_BITS each  register indices.
- addr  out  ADDR_BITS  jump target.
- imm  out  IMM_BITS  immediate.
- jop_lsb  out  1  jump-type bit.
- rd_src1, rd_src2  out  1 each  source-read enables.
- stall_cnt  out  CNT_W  load-use bubbles inserted.

Function
REQ-004 Field slicing SHALL be as follows, where D = instr[ARQ-4 -: REG_BITS], S1 = next REG_BITS below D, and S2 = next REG_BITS below S1:
- 010 MODEX, 100 CMPEQ: src1=S1, src2=S2, srcdest=D; rd_src1=1, rd_src2=1.
- 001 LDPX, 011 STPX: src1=S1, src2=0, srcdest=D; rd_src1=1.
- 101 JEQ, 110 J: addr=instr[ADDR_BITS-1:0], jop_lsb=instr[ARQ-3]; register fields 0.
- 000 SET, 111 ADD: src1=D, srcdest=D, imm=instr[IMM_BITS-1:0]; rd_src1=1.
- Every field or enable not listed for an opcode SHALL be 0.
REQ-005 All decoded outputs SHALL come from one output register, giving a latency of exactly 1 cycle from the in_valid&&in_ready edge to out_valid.
REQ-006 The output register SHALL hold its value, with out_valid high, while out_valid&&!out_ready, and all bundle fields SHALL stay stable during that time.
REQ-007 Without a hazard or flush, in_ready SHALL equal !out_valid || out_ready (combinational), so back-to-back transfers sustain 1 instruction per cycle.
REQ-008 A load-use hazard SHALL be defined as all of the following at once:
- out_valid=1 and the registered opcode is 001 (LDPX);
- in_valid=1;
- either (rd_src1 of the incoming instruction and its src1 equals the registered srcdest) or (rd_src2 of the incoming instruction and its src2 equals the registered srcdest).
REQ-009 On a hazard, in_ready SHALL be 0; if out_ready=1, the register SHALL load a bubble (out_valid=0, fields 0) and stall_cnt SHALL increment by 1.
REQ-010 After a bubble the output register no longer holds an LDPX, so the held instruction SHALL be accepted on the next cycle; exactly 1 bubble SHALL be inserted per load-use pair.
REQ-011 If a hazard occurs while out_ready=0, the stage SHALL hold, insert no bubble, and leave stall_cnt unchanged.
REQ-012 stall_cnt SHALL saturate at 2^CNT_W-1.
REQ-013 flush SHALL have priority over all other conditions and SHALL be synchronous:
- in_ready=0 during the flush cycle;
- the next state is out_valid=0 with all fields 0;
- the incoming instruction is dropped;
- stall_cnt is unchanged.
REQ-014 Opcodes not covered by REQ-004 SHALL NOT exist, since all 8 encodings are mapped; there SHALL be no default/X outputs.

Reset
REQ-015 While rst_n=0, regardless of clk, the block SHALL drive out_valid=0, all fields 0, rd_src1/rd_src2=0 and stall_cnt=0.
REQ-016 in_ready SHALL be 1 in the first cycle after rst_n rises.
REQ-017 An instruction in flight when reset asserts SHALL be lost.

Verification
REQ-018 A bench SHALL cover at least the following directed scenarios:
- Decode: instr=0x4A30 (MODEX, default params), in_valid=1, out_ready=1 -> next cycle out_valid=1, opcode=2, srcdest=2, src1=4, src2=3, rd_src1=1, rd_src2=1.
- Backpressure: out_ready=0 for 3 cycles with a valid bundle -> bundle stable, in_ready=0; out_ready=1 -> transfer, next instruction accepted that same cycle.
- Load-use: LDPX with srcdest=2 in the register, CMPEQ with src1=2 incoming, out_ready=1 -> one bubble cycle (out_valid=0), stall_cnt=1, CMPEQ valid on the following cycle.
- Flush: flush=1 with a valid bundle and valid input -> next cycle out_valid=0, input dropped, stall_cnt unchanged.
- Saturation: CNT_W=2 with 5 load-use pairs -> stall_cnt=3.
- Async reset mid-stall -> outputs clear without waiting for clk; after release, in_ready=1 and stall_cnt=0.

Source files
------------

// File: rtl/instr_decode_stage.sv
// Instruction decode pipeline stage: slices an instruction into a registered operand bundle
// and inserts a single bubble when an incoming instruction reads the register a held LDPX loads.
module instr_decode_stage #(
   parameter  int ARQ       = 16,
   parameter  int REG_BITS  = 3,
   parameter  int CNT_W     = 8,
   localparam int ADDR_BITS = ARQ - 3,
   localparam int IMM_BITS  = ARQ - 3 - REG_BITS
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [ARQ-1:0]       instr,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2:0]           opcode,
   output logic [REG_BITS-1:0]  srcdest,
   output logic [REG_BITS-1:0]  src1,
   output logic [REG_BITS-1:0]  src2,
   output logic [ADDR_BITS-1:0] addr,
   output logic [IMM_BITS-1:0]  imm,
   output logic                 jop_lsb,
   output logic                 rd_src1,
   output logic                 rd_src2,
   output logic [CNT_W-1:0]     stall_cnt
);

   localparam logic [2:0] OP_SET   = 3'b000;
   localparam logic [2:0] OP_LDPX  = 3'b001;
   localparam logic [2:0] OP_MODEX = 3'b010;
   localparam logic [2:0] OP_STPX  = 3'b011;
   localparam logic [2:0] OP_CMPEQ = 3'b100;
   localparam logic [2:0] OP_JEQ   = 3'b101;
   localparam logic [2:0] OP_J     = 3'b110;
   localparam logic [2:0] OP_ADD   = 3'b111;

   typedef struct packed {
      logic [2:0]           opcode;
      logic [REG_BITS-1:0]  srcdest;
      logic [REG_BITS-1:0]  src1;
      logic [REG_BITS-1:0]  src2;
      logic [ADDR_BITS-1:0] addr;
      logic [IMM_BITS-1:0]  imm;
      logic                 jop_lsb;
      logic                 rd_src1;
      logic                 rd_src2;
   } bundle_t;

   localparam bundle_t BUNDLE_ZERO = {$bits(bundle_t){1'b0}};

   logic [REG_BITS-1:0] fld_d_s;
   logic [REG_BITS-1:0] fld_s1_s;
   logic [REG_BITS-1:0] fld_s2_s;
   bundle_t             dec_s;
   logic                hazard_s;

   bundle_t             bundle_d;
   bundle_t             bundle_q;
   logic                out_valid_d;
   logic                out_valid_q;
   logic [CNT_W-1:0]    stall_cnt_d;
   logic [CNT_W-1:0]    stall_cnt_q;

   assign fld_d_s  = instr[ARQ-4 -: REG_BITS];
   assign fld_s1_s = instr[ARQ-4-REG_BITS -: REG_BITS];
   assign fld_s2_s = instr[ARQ-4-2*REG_BITS -: REG_BITS];

   // Decode the incoming word; every field an opcode does not use stays zero.
   always_comb begin
      dec_s        = BUNDLE_ZERO;
      dec_s.opcode = instr[ARQ-1 -: 3];
      case (instr[ARQ-1 -: 3])
         OP_MODEX, OP_CMPEQ: begin
            dec_s.srcdest = fld_d_s;
            dec_s.src1    = fld_s1_s;
            dec_s.src2    = fld_s2_s;
            dec_s.rd_src1 = 1'b1;
            dec_s.rd_src2 = 1'b1;
         end
         OP_LDPX, OP_STPX: begin
            dec_s.srcdest = fld_d_s;
            dec_s.src1    = fld_s1_s;
            dec_s.rd_src1 = 1'b1;
         end
         OP_JEQ, OP_J: begin
            dec_s.addr    = instr[ADDR_BITS-1:0];
            dec_s.jop_lsb = instr[ARQ-3];
         end
         OP_SET, OP_ADD: begin
            dec_s.srcdest = fld_d_s;
            dec_s.src1    = fld_d_s;
            dec_s.imm     = instr[IMM_BITS-1:0];
            dec_s.rd_src1 = 1'b1;
         end
         default: begin
            dec_s = BUNDLE_ZERO;
         end
      endcase
   end

   // Load-use hazard: a held LDPX whose destination the incoming instruction reads.
   always_comb begin
      hazard_s = 1'b0;
      if (out_valid_q && (bundle_q.opcode == OP_LDPX) && in_valid) begin
         hazard_s = (dec_s.rd_src1 && (dec_s.src1 == bundle_q.srcdest)) ||
                    (dec_s.rd_src2 && (dec_s.src2 == bundle_q.srcdest));
      end else begin
         hazard_s = 1'b0;
      end
   end

   assign in_ready = !flush && !hazard_s && (!out_valid_q || out_ready);

   // Output register next state: flush beats hazard, hazard beats a normal transfer.
   always_comb begin
      bundle_d    = bundle_q;
      out_valid_d = out_valid_q;
      stall_cnt_d = stall_cnt_q;
      if (flush) begin
         bundle_d    = BUNDLE_ZERO;
         out_valid_d = 1'b0;
      end else if (hazard_s) begin
         if (out_ready) begin
            bundle_d    = BUNDLE_ZERO;
            out_valid_d = 1'b0;
            stall_cnt_d = (stall_cnt_q == {CNT_W{1'b1}}) ? stall_cnt_q : stall_cnt_q + CNT_W'(1);
         end else begin
            bundle_d    = bundle_q;
            out_valid_d = out_valid_q;
         end
      end else if (in_valid && in_ready) begin
         bundle_d    = dec_s;
         out_valid_d = 1'b1;
      end else if (out_ready) begin
         // Drained with nothing behind it: keep fields zero whenever the bundle is invalid.
         bundle_d    = BUNDLE_ZERO;
         out_valid_d = 1'b0;
      end else begin
         bundle_d    = bundle_q;
         out_valid_d = out_valid_q;
      end
   end

   // Output bundle and stall counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bundle_q    <= BUNDLE_ZERO;
         out_valid_q <= 1'b0;
         stall_cnt_q <= {CNT_W{1'b0}};
      end else begin
         bundle_q    <= bundle_d;
         out_valid_q <= out_valid_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign opcode    = bundle_q.opcode;
   assign srcdest   = bundle_q.srcdest;
   assign src1      = bundle_q.src1;
   assign src2      = bundle_q.src2;
   assign addr      = bundle_q.addr;
   assign imm       = bundle_q.imm;
   assign jop_lsb   = bundle_q.jop_lsb;
   assign rd_src1   = bundle_q.rd_src1;
   assign rd_src2   = bundle_q.rd_src2;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage (default widths, 2-bit stall counter) with a
// cycle-level reference model compared on every falling edge.
module tb_instr_decode_stage;

   localparam int CW = 2;

   logic          clk       = 1'b0;
   logic          rst_n     = 1'b1;
   logic          in_valid  = 1'b0;
   logic          flush     = 1'b0;
   logic          out_ready = 1'b0;
   logic [15:0]   instr     = 16'h0000;
   logic          in_ready;
   logic          out_valid;
   logic [2:0]    opcode;
   logic [2:0]    srcdest;
   logic [2:0]    src1;
   logic [2:0]    src2;
   logic [12:0]   addr;
   logic [9:0]    imm;
   logic          jop_lsb;
   logic          rd_src1;
   logic          rd_src2;
   logic [CW-1:0] stall_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   instr_decode_stage #(.ARQ(16), .REG_BITS(3), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .opcode(opcode),
      .srcdest(srcdest), .src1(src1), .src2(src2), .addr(addr), .imm(imm),
      .jop_lsb(jop_lsb), .rd_src1(rd_src1), .rd_src2(rd_src2), .stall_cnt(stall_cnt)
   );

   typedef struct packed {
      logic [2:0]  op;
      logic [2:0]  d;
      logic [2:0]  s1;
      logic [2:0]  s2;
      logic [12:0] addr;
      logic [9:0]  imm;
      logic        jop;
      logic        r1;
      logic        r2;
   } bun_t;

   bun_t m_b     = '0;
   logic m_valid = 1'b0;
   int   m_cnt   = 0;

   // Decode by arithmetic on the 16-bit word: op=w/8192, fields are 3-bit groups below it.
   function automatic bun_t model_dec(input logic [15:0] w);
      bun_t b;
      int   u;
      int   op;
      u  = int'(w);
      op = u >> 13;
      b  = '0;
      b.op = 3'(op);
      case (op)
         2, 4: begin
            b.d = 3'(u >> 10); b.s1 = 3'(u >> 7); b.s2 = 3'(u >> 4); b.r1 = 1'b1; b.r2 = 1'b1;
         end
         1, 3: begin
            b.d = 3'(u >> 10); b.s1 = 3'(u >> 7); b.r1 = 1'b1;
         end
         5, 6: begin
            b.addr = 13'(u % 8192); b.jop = 1'(op % 2);
         end
         default: begin
            b.d = 3'(u >> 10); b.s1 = 3'(u >> 10); b.imm = 10'(u % 1024); b.r1 = 1'b1;
         end
      endcase
      return b;
   endfunction

   function automatic logic model_hz();
      bun_t nb;
      nb = model_dec(instr);
      return m_valid && (m_b.op == 3'd1) && in_valid &&
             ((nb.r1 && (nb.s1 == m_b.d)) || (nb.r2 && (nb.s2 == m_b.d)));
   endfunction

   function automatic logic exp_ready();
      return !flush && !model_hz() && (!m_valid || out_ready);
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model of the output register.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid <= 1'b0; m_b <= '0; m_cnt <= 0;
      end else if (flush) begin
         m_valid <= 1'b0; m_b <= '0;
      end else if (model_hz()) begin
         if (out_ready) begin
            m_valid <= 1'b0; m_b <= '0;
            if (m_cnt < (1 << CW) - 1) m_cnt <= m_cnt + 1;
         end
      end else if (in_valid && (!m_valid || out_ready)) begin
         m_valid <= 1'b1; m_b <= model_dec(instr);
      end else if (out_ready) begin
         m_valid <= 1'b0; m_b <= '0;
      end
   end

   // Compare DUT against model every falling edge.
   always @(negedge clk) begin
      chk("bundle", {out_valid, opcode, srcdest, src1, src2, addr, imm, jop_lsb, rd_src1, rd_src2, stall_cnt},
                    {m_valid, m_b, CW'(m_cnt)});
      chk("in_ready", in_ready, exp_ready());
   end

   task automatic cyc(input logic v, input logic [15:0] w, input logic fl, input logic ordy);
      in_valid = v; instr = w; flush = fl; out_ready = ordy;
      @(posedge clk); #1;
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_stall", stall_cnt, 0);
      chk("rst_fields", {opcode, srcdest, src1, src2, addr, imm, jop_lsb, rd_src1, rd_src2}, 0);
      #9 rst_n = 1'b1;
      #1 chk("post_rst_in_ready", in_ready, 1);

      // Decode MODEX 0x4A30
      cyc(1'b1, 16'h4A30, 1'b0, 1'b1);
      chk("dec_valid", out_valid, 1);
      chk("dec_fields", {opcode, srcdest, src1, src2, rd_src1, rd_src2}, {3'd2, 3'd2, 3'd4, 3'd3, 1'b1, 1'b1});
      chk("dec_zero", {addr, imm, jop_lsb}, 0);

      // Backpressure for three cycles, then transfer with a J accepted the same cycle
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; instr = 16'hC123; out_ready = 1'b0;
         #1 chk("bp_in_ready", in_ready, 0);
         @(posedge clk); #1;
         chk("bp_stable", {out_valid, opcode, srcdest, src1, src2}, {1'b1, 3'd2, 3'd2, 3'd4, 3'd3});
      end
      out_ready = 1'b1;
      #1 chk("bp_release_ready", in_ready, 1);
      @(posedge clk); #1;
      chk("bp_next", {out_valid, opcode, addr, jop_lsb, srcdest, rd_src1}, {1'b1, 3'd6, 13'h0123, 1'b0, 3'd0, 1'b0});
      cyc(1'b0, 16'h0000, 1'b0, 1'b1);
      chk("drain", out_valid, 0);

      // Load-use: LDPX r2 then CMPEQ reading r2
      cyc(1'b1, 16'h2A80, 1'b0, 1'b1);
      in_valid = 1'b1; instr = 16'h8160; out_ready = 1'b1;
      #1 chk("lu_in_ready", in_ready, 0);
      @(posedge clk); #1;
      chk("lu_bubble", {out_valid, stall_cnt}, {1'b0, 2'd1});
      chk("lu_accept_ready", in_ready, 1);
      @(posedge clk); #1;
      chk("lu_cmpeq", {out_valid, opcode, src1, src2, stall_cnt}, {1'b1, 3'd4, 3'd2, 3'd6, 2'd1});
      cyc(1'b0, 16'h0000, 1'b0, 1'b1);

      // Hazard while downstream stalls: hold, no bubble
      cyc(1'b1, 16'h2A80, 1'b0, 1'b1);
      cyc(1'b1, 16'h8160, 1'b0, 1'b0);
      cyc(1'b1, 16'h8160, 1'b0, 1'b0);
      chk("lu_hold", {out_valid, opcode, stall_cnt}, {1'b1, 3'd1, 2'd1});
      cyc(1'b1, 16'h8160, 1'b0, 1'b1);
      chk("lu_hold_bubble", {out_valid, stall_cnt}, {1'b0, 2'd2});
      cyc(1'b1, 16'h8160, 1'b0, 1'b1);
      cyc(1'b0, 16'h0000, 1'b0, 1'b1);

      // Flush with valid bundle and valid input
      cyc(1'b1, 16'h0CA5, 1'b0, 1'b1);
      in_valid = 1'b1; instr = 16'h9FF0; flush = 1'b1; out_ready = 1'b0;
      #1 chk("flush_in_ready", in_ready, 0);
      @(posedge clk); #1;
      chk("flush_state", {out_valid, opcode, srcdest, imm, rd_src1, stall_cnt}, {1'b0, 3'd0, 3'd0, 10'd0, 1'b0, 2'd2});
      cyc(1'b0, 16'h0000, 1'b0, 1'b1);
      chk("flush_dropped", out_valid, 0);

      // Directed mix of every opcode, src2/src1-as-D hazards and stalls
      cyc(1'b1, 16'h2A80, 1'b0, 1'b1);
      cyc(1'b1, 16'h47A0, 1'b0, 1'b1);
      cyc(1'b1, 16'h47A0, 1'b0, 1'b1);
      cyc(1'b1, 16'h3480, 1'b0, 1'b1);
      cyc(1'b1, 16'hD6D0, 1'b0, 1'b1);
      cyc(1'b1, 16'h2C00, 1'b0, 1'b1);
      cyc(1'b1, 16'h0CA5, 1'b0, 1'b0);
      cyc(1'b1, 16'h0CA5, 1'b0, 1'b1);
      cyc(1'b1, 16'h0CA5, 1'b0, 1'b1);
      cyc(1'b1, 16'h7300, 1'b0, 1'b1);
      cyc(1'b1, 16'hE9F9, 1'b0, 1'b0);
      cyc(1'b1, 16'hBFFF, 1'b0, 1'b1);
      cyc(1'b1, 16'h9FF0, 1'b0, 1'b1);
      cyc(1'b0, 16'h0000, 1'b0, 1'b1);

      // Saturation: five more load-use pairs
      for (int k = 0; k < 5; k++) begin
         cyc(1'b1, 16'h2A80, 1'b0, 1'b1);
         cyc(1'b1, 16'h8160, 1'b0, 1'b1);
         cyc(1'b1, 16'h8160, 1'b0, 1'b1);
         cyc(1'b0, 16'h0000, 1'b0, 1'b1);
      end
      chk("sat_stall", stall_cnt, 3);

      // Asynchronous reset in the middle of a held hazard
      cyc(1'b1, 16'h2A80, 1'b0, 1'b1);
      cyc(1'b1, 16'h8160, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_clear", {out_valid, opcode, srcdest, src1, rd_src1, stall_cnt}, 0);
      in_valid = 1'b0;
      #3 rst_n = 1'b1;
      #1 chk("arst_release", {in_ready, stall_cnt}, {1'b1, 2'd0});
      @(posedge clk); #1;
      chk("arst_lost", out_valid, 0);
      cyc(1'b1, 16'h4A30, 1'b0, 1'b1);
      chk("arst_redecode", {out_valid, opcode, src1}, {1'b1, 3'd2, 3'd4});
      cyc(1'b0, 16'h0000, 1'b0, 1'b1);
      cyc(1'b0, 16'h0000, 1'b0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
